// File: rtl/mux_2to1.sv
// Two-input selector with a combinational output and an enabled, registered copy
// that also counts how many captures took the True input.
// Optional macro MUX_PARITY_EN adds Parity_r, the XOR parity of the captured value.
module mux_2to1 #(
   parameter int DATA_WIDTH = 21,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [DATA_WIDTH-1:0] True,
   input  logic [DATA_WIDTH-1:0] False,
   input  logic                  Cond,
   input  logic                  En,
   output logic [DATA_WIDTH-1:0] Out,
   output logic [DATA_WIDTH-1:0] Out_r,
   output logic                  Valid_r,
`ifdef MUX_PARITY_EN
   output logic                  Parity_r,
`endif
   output logic [CNT_WIDTH-1:0]  Sel_cnt
);

   logic [DATA_WIDTH-1:0] w_sel;
   logic [DATA_WIDTH-1:0] r_out;
   logic                  r_valid;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  w_cnt_full;

   // Only a definite 1 on Cond picks True; anything else falls to False.
   always_comb begin
      w_sel = False;
      if (Cond == 1'b1) w_sel = True;
   end

   assign w_cnt_full = &r_cnt;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_out   <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else if (En) begin
         r_out   <= w_sel;
         r_valid <= 1'b1;
         if (Cond == 1'b1 && !w_cnt_full) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

`ifdef MUX_PARITY_EN
   logic r_par;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)  r_par <= 1'b0;
      else if (En) r_par <= ^w_sel;
   end

   assign Parity_r = r_par;
`endif

   assign Out     = w_sel;
   assign Out_r   = r_out;
   assign Valid_r = r_valid;
   assign Sel_cnt = r_cnt;

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: stimulus pushes expected register state per edge,
// a negedge monitor pops and compares; a CNT_WIDTH=2 copy exercises saturation.
module tb_mux_2to1;

   localparam int DW = 21;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic [DW-1:0] True, False;
   logic          Cond, En;
   logic [DW-1:0] Out, Out_r, s_out, s_out_r;
   logic          Valid_r, s_valid;
   logic [15:0]   Sel_cnt;
   logic [1:0]    s_cnt;
`ifdef MUX_PARITY_EN
   logic          Parity_r, s_par;
`endif

   always #5 Clk = ~Clk;

   mux_2to1 #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .True(True), .False(False), .Cond(Cond), .En(En),
      .Out(Out), .Out_r(Out_r), .Valid_r(Valid_r),
`ifdef MUX_PARITY_EN
      .Parity_r(Parity_r),
`endif
      .Sel_cnt(Sel_cnt));

   mux_2to1 #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_sat (
      .Clk(Clk), .Rst_n(Rst_n), .True(True), .False(False), .Cond(Cond), .En(En),
      .Out(s_out), .Out_r(s_out_r), .Valid_r(s_valid),
`ifdef MUX_PARITY_EN
      .Parity_r(s_par),
`endif
      .Sel_cnt(s_cnt));

   typedef struct {
      logic [DW-1:0] out_r;
      logic          valid;
      int unsigned   cnt;
      int unsigned   cnt2;
      logic          par;
   } exp_t;

   exp_t q[$];

   // Reference state: what the registered outputs should read after each edge.
   logic [DW-1:0] m_out;
   logic          m_valid, m_par;
   int unsigned   m_captures_true;

   int n_vec = 0;
   int n_err = 0;

   function automatic int unsigned sat(int unsigned v, int unsigned maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = '0; m_valid = 1'b0; m_par = 1'b0; m_captures_true = 0;
   endtask

   // One clock edge: update the model from the inputs held across it, queue the result.
   task automatic step();
      exp_t e;
      @(posedge Clk);
      if (!Rst_n) model_reset();
      else if (En) begin
         m_out   = Cond ? True : False;
         m_valid = 1'b1;
         m_par   = ^m_out;
         if (Cond) m_captures_true++;
      end
      e.out_r = m_out;
      e.valid = m_valid;
      e.cnt   = sat(m_captures_true, 65535);
      e.cnt2  = sat(m_captures_true, 3);
      e.par   = m_par;
      q.push_back(e);
      @(negedge Clk);
      #1;
   endtask

   task automatic check_comb(input string name);
      #1;
      check(name, 32'(Out), Cond ? 32'(True) : 32'(False));
   endtask

   task automatic async_reset_check(input string name);
      Rst_n = 1'b0;
      model_reset();
      #1;
      check({name, "_out_r"}, 32'(Out_r), 32'd0);
      check({name, "_valid"}, 32'(Valid_r), 32'd0);
      check({name, "_cnt"},   32'(Sel_cnt), 32'd0);
      check({name, "_cnt2"},  32'(s_cnt), 32'd0);
`ifdef MUX_PARITY_EN
      check({name, "_par"},   32'(Parity_r), 32'd0);
`endif
   endtask

   always @(negedge Clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         check("out_r", 32'(Out_r),   32'(e.out_r));
         check("valid", 32'(Valid_r), 32'(e.valid));
         check("cnt",   32'(Sel_cnt), e.cnt);
         check("cnt2",  32'(s_cnt),   e.cnt2);
`ifdef MUX_PARITY_EN
         check("parity", 32'(Parity_r), 32'(e.par));
`endif
      end
   end

   initial begin
      int budget;
      True = 21'd100; False = 21'd7; Cond = 1'b1; En = 1'b1;
      model_reset();
      async_reset_check("por");
      check_comb("out_in_reset");
      step();                      // En ignored while held in reset
      @(negedge Clk); #1;
      Rst_n = 1'b1;

      // Combinational path
      Cond = 1'b1; check_comb("comb_true_100");
      Cond = 1'b0; check_comb("comb_false_7");
      En = 1'b0;   check_comb("comb_en_low");

      // Max value capture, then hold with En low
      En = 1'b1; Cond = 1'b1; True = 21'h1FFFFF;
      step();
      En = 1'b0; True = 21'd5;
      step();

      // Repeated False captures leave the counter alone
      En = 1'b1; Cond = 1'b0; False = 21'd42;
      repeat (3) step();

      // Saturate the narrow counter
      Cond = 1'b1; True = 21'h0ABCDE;
      repeat (5) step();

      // Reset asserted between edges after captures
      async_reset_check("mid_rst");
      Cond = 1'b0; check_comb("out_during_rst");
      Cond = 1'b1; check_comb("out_during_rst2");
      step();
      Rst_n = 1'b1;

      // Parity-style captures (odd then even popcount)
      En = 1'b1; Cond = 1'b1; True = 21'h7;
      step();
      True = 21'h3;
      step();

      // Randomized traffic with occasional mid-cycle resets
      for (int i = 0; i < 400; i++) begin
         True  = DW'($urandom);
         False = DW'($urandom);
         Cond  = 1'($urandom);
         En    = ($urandom_range(0, 3) != 0);
         check_comb("rand_comb");
         if ($urandom_range(0, 39) == 0) begin
            async_reset_check("rand_rst");
            step();
            Rst_n = 1'b1;
         end else begin
            step();
         end
      end

      budget = 0;
      while (q.size() != 0 && budget < 10) begin
         @(negedge Clk); #1;
         budget++;
      end
      if (q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_2to1.md
MUX_2TO1 -- requirements
Module: mux_2to1

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 21, width of True/False/Out/Out_r.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of Sel_cnt.
REQ-003 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port True  input  DATA_WIDTH  data passed when Cond=1.
REQ-006 SHALL have port False  input  DATA_WIDTH  data passed when Cond=0.
REQ-007 SHALL have port Cond  input  1  select.
REQ-008 SHALL have port En  input  1  capture enable for the registered stage.
REQ-009 SHALL have port Out  output  DATA_WIDTH  combinational selection.
REQ-010 SHALL have port Out_r  output  DATA_WIDTH  registered selection.
REQ-011 SHALL have port Valid_r  output  1  Out_r holds a captured value.
REQ-012 SHALL have port Sel_cnt  output  CNT_WIDTH  count of captures with Cond=1.

Function
REQ-013 Out SHALL equal True when Cond=1, else False; purely combinational, zero cycles, independent of Clk, Rst_n, En.
REQ-014 Cond X/Z SHALL not be special-cased; only 1 selects True.
REQ-015 On rising Clk with En=1, Out_r SHALL load the REQ-013 value and Valid_r SHALL become 1; latency one cycle.
REQ-016 On rising Clk with En=0, Out_r, Valid_r, Sel_cnt SHALL hold.
REQ-017 On rising Clk with En=1 and Cond=1, Sel_cnt SHALL increment by 1, saturating at all-ones (no wrap).
REQ-018 Values are unsigned, passed bit-exact; no width extension or truncation.
REQ-019 Valid_r, once set, SHALL stay 1 until reset.

Reset
REQ-020 Rst_n=0 SHALL immediately (no clock) force Out_r=0, Valid_r=0, Sel_cnt=0.
REQ-021 While Rst_n=0, En SHALL be ignored; Out SHALL still follow REQ-013.
REQ-022 First capture SHALL occur on the first rising Clk with Rst_n=1 and En=1; reset asserted between edges discards prior state.

Configuration
REQ-023 Macro MUX_PARITY_EN: when defined, SHALL add output Parity_r (1 bit) = even-parity XOR of the value loaded into Out_r, updated with Out_r, reset to 0.
REQ-024 Without MUX_PARITY_EN, Parity_r SHALL not exist; all other behaviour identical.

Verification
REQ-025 Cond=1, True=100, False=7 -> Out=100 within 1 time unit; Cond=0 -> Out=7.
REQ-026 Rst_n=0 mid-cycle after captures -> Out_r=0, Valid_r=0, Sel_cnt=0 before next Clk; Out still follows Cond.
REQ-027 En=1, Cond=1, True=0x1FFFFF, one edge -> Out_r=0x1FFFFF, Valid_r=1, Sel_cnt=1; next edge En=0, True=5 -> Out_r unchanged.
REQ-028 En=1, Cond=0, False=42 for 3 edges -> Out_r=42, Sel_cnt unchanged.
REQ-029 CNT_WIDTH=2, En=1, Cond=1 for 5 edges -> Sel_cnt=3 (saturated).
REQ-030 With MUX_PARITY_EN, capture True=0x7 -> Parity_r=1; capture 0x3 -> Parity_r=0.
